// File: rtl/sample_loader_pkg.sv
// sample_loader_pkg: widths and frame types shared by the sample loader and the downstream 8-point FFT stage.
package sample_loader_pkg;
  localparam int DATA_W = 8;
  localparam int N_PTS  = 8;
  localparam int IDX_W  = 3;
  localparam int CNT_W  = 8;
  typedef logic [DATA_W-1:0] sample_t;
  typedef sample_t [N_PTS-1:0] frame_t;
endpackage

// File: rtl/sample_loader_if.sv
// sample_loader_if: sample stream in, frame samples and status out.
interface sample_loader_if;
  import sample_loader_pkg::*;
  sample_t din;
  logic din_valid;
  logic sync;
  sample_t x0_re, x1_re, x2_re, x3_re, x4_re, x5_re, x6_re, x7_re;
  logic frame_valid;
  logic [IDX_W-1:0] fill_idx;
  logic [CNT_W-1:0] frame_cnt;
  logic resync_err;
  modport master (
    output din, din_valid, sync,
    input x0_re, x1_re, x2_re, x3_re, x4_re, x5_re, x6_re, x7_re,
    input frame_valid, fill_idx, frame_cnt, resync_err
  );
  modport slave (
    input din, din_valid, sync,
    output x0_re, x1_re, x2_re, x3_re, x4_re, x5_re, x6_re, x7_re,
    output frame_valid, fill_idx, frame_cnt, resync_err
  );
endinterface

// File: rtl/sample_shadow_buf.sv
// sample_shadow_buf: 8x8 register file with one indexed write port and a full parallel read.
module sample_shadow_buf
  import sample_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_widx,
  input  sample_t          i_wdata,
  output frame_t           o_rd
);
  frame_t r_mem;
  always_ff @(posedge clk) begin
    if (rst) r_mem <= '0;
    else if (i_we) r_mem[i_widx] <= i_wdata;
  end
  assign o_rd = r_mem;
endmodule

// File: rtl/sample_loader.sv
// sample_loader: fills a shadow buffer from a sample stream and swaps complete 8-sample frames into a registered active buffer.
module sample_loader #(
  parameter int DATA_W = 8,
  parameter int N_PTS  = 8
) (
  input logic clk,
  input logic rst,
  sample_loader_if.slave b
);
  import sample_loader_pkg::*;
  logic [N_PTS-1:0][DATA_W-1:0] r_active;
  frame_t w_shadow;
  logic [IDX_W-1:0] r_fill;
  logic [CNT_W-1:0] r_cnt;
  logic r_fv;
  logic r_err;
  logic w_sync;
  logic w_last;
  logic [IDX_W-1:0] w_widx;
  always_comb begin
    w_sync = b.din_valid & b.sync;
    w_last = b.din_valid & ~b.sync & (r_fill == IDX_W'(N_PTS - 1));
    w_widx = w_sync ? '0 : r_fill;
  end
  sample_shadow_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_we    (b.din_valid),
    .i_widx  (w_widx),
    .i_wdata (b.din),
    .o_rd    (w_shadow)
  );
  // The last sample bypasses the shadow buffer so the swap lands one cycle after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= '0;
      r_fill   <= '0;
      r_cnt    <= '0;
      r_fv     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (b.din_valid) r_fill <= w_sync ? IDX_W'(1) : r_fill + 1'b1;
      if (w_sync && r_fill != '0) r_err <= 1'b1;
      if (w_last) begin
        r_active <= {b.din, w_shadow[N_PTS-2:0]};
        r_cnt    <= r_cnt + 1'b1;
      end
      r_fv <= w_last;
    end
  end
  assign b.x0_re       = r_active[0];
  assign b.x1_re       = r_active[1];
  assign b.x2_re       = r_active[2];
  assign b.x3_re       = r_active[3];
  assign b.x4_re       = r_active[4];
  assign b.x5_re       = r_active[5];
  assign b.x6_re       = r_active[6];
  assign b.x7_re       = r_active[7];
  assign b.frame_valid = r_fv;
  assign b.fill_idx    = r_fill;
  assign b.frame_cnt   = r_cnt;
  assign b.resync_err  = r_err;
endmodule
